// File: rtl/vga_timing_gen.sv
// Raster timing generator: free-running pixel/line counters for the video-memory
// read address, with sync and blank delayed to line up with the memory read data.
module vga_timing_gen #(
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33,
  parameter bit SYNC_POL = 1'b0,
  parameter int PIPE_DLY = 1
) (
  input  logic        clka,
  input  logic        rst_n,
  input  logic        irq_clr,
  output logic [9:0]  pixel_count,
  output logic [9:0]  line_count,
  output logic        hsync,
  output logic        vsync,
  output logic        video_on,
  output logic        frame_start,
  output logic        vblank_irq,
  output logic [15:0] frame_cnt
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [9:0]  H_LAST      = 10'(H_TOTAL - 1);
  localparam logic [9:0]  V_LAST      = 10'(V_TOTAL - 1);
  localparam logic [9:0]  V_IRQ_LINE  = 10'(V_ACTIVE);
  localparam logic [10:0] H_ACT_END   = 11'(H_ACTIVE);
  localparam logic [10:0] H_SYNC_BEG  = 11'(H_ACTIVE + H_FP);
  localparam logic [10:0] H_SYNC_END  = 11'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [10:0] V_ACT_END   = 11'(V_ACTIVE);
  localparam logic [10:0] V_SYNC_BEG  = 11'(V_ACTIVE + V_FP);
  localparam logic [10:0] V_SYNC_END  = 11'(V_ACTIVE + V_FP + V_SYNC);

  // Delay-line bit positions within each stage.
  localparam int B_HS  = 0;
  localparam int B_VS  = 1;
  localparam int B_VID = 2;

  logic [9:0]  pix_q, pix_d;
  logic [9:0]  line_q, line_d;
  logic        frame_start_q, frame_start_d;
  logic [15:0] frame_cnt_q, frame_cnt_d;
  logic        irq_q, irq_d;
  logic [2:0]  dly_q [PIPE_DLY];
  logic [2:0]  dly_d [PIPE_DLY];

  logic        pix_wrap;
  logic        line_wrap;
  logic        frame_wrap;
  logic        vblank_set;
  logic [10:0] pix_ext;
  logic [10:0] line_ext;
  logic        h_act;
  logic        v_act;
  logic        hs_raw;
  logic        vs_raw;
  logic        vid_raw;

  // Raster counters
  always_comb begin
    pix_wrap  = (pix_q == H_LAST);
    line_wrap = (line_q == V_LAST);
    pix_d     = pix_wrap ? 10'd0 : pix_q + 10'd1;
    line_d    = line_q;
    if (pix_wrap) begin
      line_d = line_wrap ? 10'd0 : line_q + 10'd1;
    end
  end

  // Raw decode from the undelayed counters; widened so a 1024 total still compares correctly.
  always_comb begin
    pix_ext  = {1'b0, pix_q};
    line_ext = {1'b0, line_q};
    h_act    = (pix_ext < H_ACT_END);
    v_act    = (line_ext < V_ACT_END);
    hs_raw   = (pix_ext >= H_SYNC_BEG) && (pix_ext < H_SYNC_END);
    vs_raw   = (line_ext >= V_SYNC_BEG) && (line_ext < V_SYNC_END);
    vid_raw  = h_act & v_act;
  end

  // frame_start is registered off the wrap, so the reset-held (0,0) never pulses it.
  always_comb begin
    frame_wrap    = pix_wrap & line_wrap;
    frame_start_d = frame_wrap;
    frame_cnt_d   = frame_cnt_q + 16'(frame_wrap);
  end

  always_comb begin
    vblank_set = (pix_q == 10'd0) && (line_q == V_IRQ_LINE);
    irq_d      = irq_q;
    if (irq_clr) begin
      irq_d = 1'b0;
    end
    if (vblank_set) begin
      irq_d = 1'b1;
    end
  end

  always_comb begin
    dly_d[0] = '0;
    dly_d[0][B_HS]  = hs_raw;
    dly_d[0][B_VS]  = vs_raw;
    dly_d[0][B_VID] = vid_raw;
    for (int i = 1; i < PIPE_DLY; i++) begin
      dly_d[i] = dly_q[i-1];
    end
  end

  always_ff @(posedge clka) begin
    if (!rst_n) begin
      pix_q         <= '0;
      line_q        <= '0;
      frame_start_q <= 1'b0;
      frame_cnt_q   <= '0;
      irq_q         <= 1'b0;
    end else begin
      pix_q         <= pix_d;
      line_q        <= line_d;
      frame_start_q <= frame_start_d;
      frame_cnt_q   <= frame_cnt_d;
      irq_q         <= irq_d;
    end
  end

  // Stages hold active-high flags; reset clears them so no sync pulse survives a reset.
  always_ff @(posedge clka) begin
    if (!rst_n) begin
      for (int i = 0; i < PIPE_DLY; i++) begin
        dly_q[i] <= '0;
      end
    end else begin
      dly_q <= dly_d;
    end
  end

  always_comb begin
    pixel_count = pix_q;
    line_count  = line_q;
    hsync       = dly_q[PIPE_DLY-1][B_HS] ? SYNC_POL : ~SYNC_POL;
    vsync       = dly_q[PIPE_DLY-1][B_VS] ? SYNC_POL : ~SYNC_POL;
    video_on    = dly_q[PIPE_DLY-1][B_VID];
    frame_start = frame_start_q;
    vblank_irq  = irq_q;
    frame_cnt   = frame_cnt_q;
  end

endmodule
